bcd_score_counter: RTL and testbench

BCD_SCORE_COUNTER -- requirements
Module: bcd_score_counter

---
 rtl/bcd_score_counter.sv | 149 ++++++++++++++
 tb/tb_bcd_score_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: cascaded BCD up/down counter with parallel load,
// wrap-or-clamp limit handling and one-cycle overflow/underflow pulses.
// Carry and borrow ripple through every digit combinationally, so a
// step always lands in one clock.
module bcd_score_counter #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  up,
    input  logic [3:0]            step,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   value,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  is_zero
);

    localparam int W = 4 * DIGITS;

    // Registered state
    logic [W-1:0] r_value;
    logic         r_overflow;
    logic         r_underflow;

    // Combinational helpers
    logic [3:0]   w_step;
    logic [W-1:0] w_load_clamped;
    logic [W-1:0] w_add;
    logic [W-1:0] w_sub;
    logic         w_carry;
    logic         w_borrow;
    logic [3:0]   w_digit;
    logic [3:0]   w_op;
    logic [4:0]   w_sum;
    logic [4:0]   w_sum_adj;
    logic [4:0]   w_need;
    logic [4:0]   w_diff;
    logic [4:0]   w_diff_wrap;
    logic [3:0]   w_ld_digit;
    logic [W-1:0] w_next_value;
    logic         w_next_overflow;
    logic         w_next_underflow;

    // Clamp illegal BCD digits on the step and the load value to 9
    always_comb begin
        w_step         = (step > 4'd9) ? 4'd9 : step;
        w_load_clamped = {W{1'b0}};
        w_ld_digit     = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_ld_digit = load_value[i*4 +: 4];
            if (w_ld_digit > 4'd9) begin
                w_load_clamped[i*4 +: 4] = 4'd9;
            end else begin
                w_load_clamped[i*4 +: 4] = w_ld_digit;
            end
        end
    end

    // Decimal add and subtract of the step, rippling carry/borrow across digits
    always_comb begin
        w_add       = {W{1'b0}};
        w_sub       = {W{1'b0}};
        w_carry     = 1'b0;
        w_borrow    = 1'b0;
        w_digit     = 4'd0;
        w_op        = 4'd0;
        w_sum       = 5'd0;
        w_sum_adj   = 5'd0;
        w_need      = 5'd0;
        w_diff      = 5'd0;
        w_diff_wrap = 5'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_digit = r_value[i*4 +: 4];
            w_op    = (i == 0) ? w_step : 4'd0;
            // add path
            w_sum     = {1'b0, w_digit} + {1'b0, w_op} + {4'd0, w_carry};
            w_sum_adj = w_sum - 5'd10;
            if (w_sum > 5'd9) begin
                w_add[i*4 +: 4] = w_sum_adj[3:0];
                w_carry         = 1'b1;
            end else begin
                w_add[i*4 +: 4] = w_sum[3:0];
                w_carry         = 1'b0;
            end
            // subtract path: modulo-32 arithmetic keeps the low nibble correct
            w_need      = {1'b0, w_op} + {4'd0, w_borrow};
            w_diff      = {1'b0, w_digit} - w_need;
            w_diff_wrap = w_diff + 5'd10;
            if ({1'b0, w_digit} < w_need) begin
                w_sub[i*4 +: 4] = w_diff_wrap[3:0];
                w_borrow        = 1'b1;
            end else begin
                w_sub[i*4 +: 4] = w_diff[3:0];
                w_borrow        = 1'b0;
            end
        end
    end

    // Select next value and limit flags: load beats count, count beats hold
    always_comb begin
        w_next_value     = r_value;
        w_next_overflow  = 1'b0;
        w_next_underflow = 1'b0;
        if (load) begin
            w_next_value = w_load_clamped;
        end else if (enable) begin
            if (up) begin
                if (w_carry) begin
                    w_next_overflow = 1'b1;
                    w_next_value    = SATURATE ? {DIGITS{4'd9}} : w_add;
                end else begin
                    w_next_value = w_add;
                end
            end else begin
                if (w_borrow) begin
                    w_next_underflow = 1'b1;
                    w_next_value     = SATURATE ? {W{1'b0}} : w_sub;
                end else begin
                    w_next_value = w_sub;
                end
            end
        end else begin
            w_next_value = r_value;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_value     <= {W{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_value     <= w_next_value;
            r_overflow  <= w_next_overflow;
            r_underflow <= w_next_underflow;
        end
    end

    assign value     = r_value;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign is_zero   = (r_value == {W{1'b0}});

endmodule

// File: tb/tb_bcd_score_counter.sv
// Scoreboard bench for bcd_score_counter: one wrapping and one saturating
// instance share stimulus; an integer reference model predicts both.
module tb_bcd_score_counter;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         enable = 1'b0;
    logic         up = 1'b0;
    logic [3:0]   step = 4'd0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = 16'h0000;

    logic [W-1:0] value0, value1;
    logic         ov0, un0, z0, ov1, un1, z1;

    always #5 clock = ~clock;

    bcd_score_counter #(.DIGITS(4), .SATURATE(1'b0)) dut_wrap (
        .clock(clock), .resetn(resetn), .enable(enable), .up(up), .step(step),
        .load(load), .load_value(load_value), .value(value0),
        .overflow(ov0), .underflow(un0), .is_zero(z0));

    bcd_score_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
        .clock(clock), .resetn(resetn), .enable(enable), .up(up), .step(step),
        .load(load), .load_value(load_value), .value(value1),
        .overflow(ov1), .underflow(un1), .is_zero(z1));

    typedef struct {
        int v0; bit o0; bit u0;
        int v1; bit o1; bit u1;
    } exp_t;

    exp_t q[$];
    int m0 = 0;
    int m1 = 0;
    int tests = 0;
    int fails = 0;

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r;
        int k;
        int d;
        r = 16'h0000;
        k = n;
        for (int i = 0; i < 4; i++) begin
            d = k % 10;
            r[i*4 +: 4] = d[3:0];
            k = k / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Apply one cycle of inputs and push the model's prediction
    task automatic drive(input bit rn, input bit en, input bit u, input bit ld,
                         input logic [3:0] st, input logic [W-1:0] lv);
        exp_t e;
        int s, t, lvi, dg;
        @(negedge clock);
        resetn = rn; enable = en; up = u; load = ld; step = st; load_value = lv;
        e.o0 = 1'b0; e.u0 = 1'b0; e.o1 = 1'b0; e.u1 = 1'b0;
        if (!rn) begin
            m0 = 0; m1 = 0;
        end else if (ld) begin
            lvi = 0;
            for (int i = 3; i >= 0; i--) begin
                dg = int'(lv[i*4 +: 4]);
                if (dg > 9) dg = 9;
                lvi = lvi * 10 + dg;
            end
            m0 = lvi; m1 = lvi;
        end else if (en) begin
            s = (int'(st) > 9) ? 9 : int'(st);
            if (u) begin
                t = m0 + s;
                if (t > 9999) begin m0 = t - 10000; e.o0 = 1'b1; end else m0 = t;
                t = m1 + s;
                if (t > 9999) begin m1 = 9999; e.o1 = 1'b1; end else m1 = t;
            end else begin
                t = m0 - s;
                if (t < 0) begin m0 = t + 10000; e.u0 = 1'b1; end else m0 = t;
                t = m1 - s;
                if (t < 0) begin m1 = 0; e.u1 = 1'b1; end else m1 = t;
            end
        end
        e.v0 = m0; e.v1 = m1;
        q.push_back(e);
    endtask

    // Monitor: after each edge, compare both instances with the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("wrap_value", value0, to_bcd(e.v0));
                check("wrap_flags", {14'd0, ov0, un0}, {14'd0, e.o0, e.u0});
                check("wrap_is_zero", {15'd0, z0}, {15'd0, (e.v0 == 0)});
                check("sat_value", value1, to_bcd(e.v1));
                check("sat_flags", {14'd0, ov1, un1}, {14'd0, e.o1, e.u1});
                check("sat_is_zero", {15'd0, z1}, {15'd0, (e.v1 == 0)});
            end
        end
    end

    // Stimulus: directed boundary cases, then randomized traffic
    initial begin
        logic [W-1:0] lv;
        int r;
        drive(0, 1, 1, 0, 4'd1, 16'h0000);
        drive(0, 0, 0, 0, 4'd0, 16'h0000);
        // carry ripple
        drive(1, 0, 0, 1, 4'd0, 16'h0099);
        drive(1, 1, 1, 0, 4'd1, 16'h0000);
        // top limit crossing, then flag must drop
        drive(1, 0, 0, 1, 4'd0, 16'h9999);
        drive(1, 1, 1, 0, 4'd1, 16'h0000);
        drive(1, 0, 1, 0, 4'd1, 16'h0000);
        // saturating add twice
        drive(1, 0, 0, 1, 4'd0, 16'h9995);
        drive(1, 1, 1, 0, 4'd7, 16'h0000);
        drive(1, 1, 1, 0, 4'd7, 16'h0000);
        // step 0 at the top: hold, no pulse
        drive(1, 0, 0, 1, 4'd0, 16'h9999);
        drive(1, 1, 1, 0, 4'd0, 16'h0000);
        // borrow below zero
        drive(1, 0, 0, 1, 4'd0, 16'h0003);
        drive(1, 1, 0, 0, 4'd5, 16'h0000);
        drive(1, 0, 0, 0, 4'd0, 16'h0000);
        // subtract from exactly 0, and step 0 at 0
        drive(1, 0, 0, 1, 4'd0, 16'h0000);
        drive(1, 1, 0, 0, 4'd0, 16'h0000);
        drive(1, 1, 0, 0, 4'd1, 16'h0000);
        // load wins over enable, digit A clamps to 9
        drive(1, 1, 1, 1, 4'd3, 16'h12A4);
        // illegal step
        drive(1, 0, 0, 1, 4'd0, 16'h0000);
        drive(1, 1, 1, 0, 4'hF, 16'h0000);
        // reset mid-count, then resume from 0
        drive(1, 1, 1, 0, 4'd1, 16'h0000);
        drive(0, 1, 1, 0, 4'd1, 16'h0000);
        drive(1, 1, 1, 0, 4'd1, 16'h0000);
        drive(1, 1, 1, 0, 4'd1, 16'h0000);
        // randomized traffic with near-limit loads
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 2));
            if (r == 0)      lv = to_bcd(9990 + int'($urandom_range(0, 9)));
            else if (r == 1) lv = to_bcd(int'($urandom_range(0, 9)));
            else             lv = 16'($urandom);
            drive(($urandom % 50) != 0, ($urandom % 4) != 0, 1'($urandom),
                  ($urandom % 10) == 0, 4'($urandom), lv);
        end
        repeat (3) @(negedge clock);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
